regfile_access_ctrl: RTL and testbench

Controller that sequences and shares the 16x16 register file's single write port and decodes its two read ports. It sits between the pipeline (writeback and decode stages), a debug/init write port, and the register array of bit cells. It drives the array's per-register write enables and per-port read enables. After every reset it runs a clear sequence that zeroes all registers. It also produces write-to-read bypass selects so decode sees same-cycle writeback data.

---
 rtl/regfile_access_ctrl.sv | 147 ++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Write-port sequencer, read-port decoder and bypass for the 16x16 register file; clears all registers after reset.
// Latency: writes commit on the edge of the grant cycle (zero wait); read enables and bypass selects are combinational.
// Backpressure: busy holds the pipeline during clear; debug requests wait behind writeback, with stall forcing a debug slot after prolonged waiting.
module regfile_access_ctrl #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_we,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                dbg_req,
    input  logic [ADDR_W-1:0]   dbg_addr,
    input  logic [DATA_W-1:0]   dbg_data,
    output logic                dbg_ack,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic [NUM_REGS-1:0] rf_wen,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic [NUM_REGS-1:0] rf_ren1,
    output logic [NUM_REGS-1:0] rf_ren2,
    output logic                byp1,
    output logic                byp2,
    output logic                busy,
    output logic                stall
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [1:0]          wcnt_q, wcnt_d;
    logic                stall_q, stall_d;
    logic                wr_vld;
    logic [ADDR_W-1:0]   wr_addr;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // State, clear counter, debug wait counter and stall flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            stall_q <= stall_d;
        end
    end

    // Next state, write-port arbitration and starvation tracking.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wcnt_d   = wcnt_q;
        stall_d  = stall_q;
        wr_vld   = 1'b0;
        wr_addr  = '0;
        rf_wen   = '0;
        rf_wdata = '0;
        dbg_ack  = 1'b0;
        busy     = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                // Walk every register including R0, writing zero.
                busy    = 1'b1;
                rf_wen  = onehot(cnt_q);
                cnt_d   = cnt_q + CNT_ONE;
                wcnt_d  = '0;
                stall_d = 1'b0;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                // Writeback first; a writeback aimed at R0 is a no-op and leaves the port to debug.
                if (wb_we && (wb_addr != '0)) begin
                    wr_vld   = 1'b1;
                    wr_addr  = wb_addr;
                    rf_wdata = wb_data;
                end else if (dbg_req) begin
                    // A debug write to R0 is retired without touching the array.
                    dbg_ack = 1'b1;
                    if (dbg_addr != '0) begin
                        wr_vld   = 1'b1;
                        wr_addr  = dbg_addr;
                        rf_wdata = dbg_data;
                    end
                end
                if (wr_vld) begin
                    rf_wen = onehot(wr_addr);
                end

                // stall rises on the edge where the wait count reaches 3, so the
                // pipeline sees it during the fourth waiting cycle and leaves the
                // following cycle free for debug; it drops on the ack edge.
                if (!dbg_req || dbg_ack) begin
                    wcnt_d  = '0;
                    stall_d = 1'b0;
                end else begin
                    if (wcnt_q != 2'd3) begin
                        wcnt_d = wcnt_q + 2'd1;
                    end
                    if (wcnt_q >= 2'd2) begin
                        stall_d = 1'b1;
                    end
                end
            end
        endcase

        // While reset is held the array must see no writes and no handshakes.
        if (!rst) begin
            wr_vld   = 1'b0;
            rf_wen   = '0;
            rf_wdata = '0;
            dbg_ack  = 1'b0;
            busy     = 1'b1;
        end
    end

    // Read decode is independent of state so the array read path is always driven.
    assign rf_ren1 = onehot(rd_addr1);
    assign rf_ren2 = onehot(rd_addr2);

    // Bypass only for a real write; wr_vld is never set during clear or for R0.
    assign byp1  = wr_vld && (wr_addr == rd_addr1);
    assign byp2  = wr_vld && (wr_addr == rd_addr2);
    assign stall = stall_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
module tb_regfile_access_ctrl;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        dbg_req;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic        dbg_ack;
    logic [3:0]  rd_addr1;
    logic [3:0]  rd_addr2;
    logic [15:0] rf_wen;
    logic [15:0] rf_wdata;
    logic [15:0] rf_ren1;
    logic [15:0] rf_ren2;
    logic        byp1;
    logic        byp2;
    logic        busy;
    logic        stall;

    int checks;
    int errors;

    // Behavioural register array driven by the controller outputs.
    logic [15:0] mem [16];
    logic        poison;

    regfile_access_ctrl #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ack(dbg_ack),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rf_wen(rf_wen), .rf_wdata(rf_wdata), .rf_ren1(rf_ren1), .rf_ren2(rf_ren2),
        .byp1(byp1), .byp2(byp2), .busy(busy), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array model: poisoned with 0xDEAD until the controller takes over.
    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (poison) mem[i] <= 16'hDEAD;
            else if (rf_wen[i]) mem[i] <= rf_wdata;
        end
    end

    function automatic logic [15:0] arr_rd(input logic [15:0] ren);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) if (ren[i]) r = r | mem[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_we = 0; wb_addr = 0; wb_data = 0;
        dbg_req = 0; dbg_addr = 0; dbg_data = 0;
    endtask

    task automatic test_reset();
        rst = 0; poison = 1;
        wb_we = 1; wb_addr = 4'd5; wb_data = 16'hFFFF;
        dbg_req = 1; dbg_addr = 4'd4; dbg_data = 16'h5555;
        rd_addr1 = 4'd3; rd_addr2 = 4'd9;
        tick(); tick();
        poison = 0;
        #1;
        checks++; if (rf_wen !== 16'h0000) begin errors++; $display("FAIL reset_rf_wen got %h want 0000", rf_wen); end
        checks++; if (rf_wdata !== 16'h0000) begin errors++; $display("FAIL reset_rf_wdata got %h want 0000", rf_wdata); end
        checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL reset_dbg_ack got %b want 0", dbg_ack); end
        checks++; if ({byp1, byp2} !== 2'b00) begin errors++; $display("FAIL reset_byp got %b want 00", {byp1, byp2}); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
        checks++; if (rf_ren1 !== 16'h0008) begin errors++; $display("FAIL reset_ren1 got %h want 0008", rf_ren1); end
        checks++; if (rf_ren2 !== 16'h0200) begin errors++; $display("FAIL reset_ren2 got %h want 0200", rf_ren2); end
    endtask

    task automatic test_clear();
        logic [15:0] exp_wen;
        tick();
        rst = 1;
        for (int k = 0; k < 16; k++) begin
            rd_addr1 = 4'(k);
            #1;
            exp_wen = 16'h0001 << k;
            checks++; if (rf_wen !== exp_wen) begin errors++; $display("FAIL clear_wen[%0d] got %h want %h", k, rf_wen, exp_wen); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy[%0d] got %b want 1", k, busy); end
            checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL clear_ack[%0d] got %b want 0", k, dbg_ack); end
            checks++; if (byp1 !== 1'b0 || rf_wdata !== 16'h0) begin errors++; $display("FAIL clear_byp_wdata[%0d] got %b/%h want 0/0000", k, byp1, rf_wdata); end
            if (k == 15) idle_inputs();
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy_done got %b want 0", busy); end
        checks++; if (rf_wen !== 16'h0000) begin errors++; $display("FAIL clear_idle_wen got %h want 0000", rf_wen); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (mem[i] !== 16'h0000) begin errors++; $display("FAIL clear_reg[%0d] got %h want 0000", i, mem[i]); end
        end
    endtask

    task automatic test_writeback();
        wb_we = 1; wb_addr = 4'd5; wb_data = 16'hBEEF;
        rd_addr1 = 4'd5; rd_addr2 = 4'd6;
        #1;
        checks++; if (rf_wen !== 16'h0020) begin errors++; $display("FAIL wb_wen got %h want 0020", rf_wen); end
        checks++; if (rf_wdata !== 16'hBEEF) begin errors++; $display("FAIL wb_wdata got %h want beef", rf_wdata); end
        checks++; if ({byp1, byp2} !== 2'b10) begin errors++; $display("FAIL wb_byp got %b want 10", {byp1, byp2}); end
        tick();
        wb_addr = 4'd9; wb_data = 16'h1357; rd_addr2 = 4'd9;
        #1;
        checks++; if ({byp1, byp2} !== 2'b01) begin errors++; $display("FAIL wb_byp2 got %b want 01", {byp1, byp2}); end
        checks++; if (arr_rd(rf_ren1) !== 16'hBEEF) begin errors++; $display("FAIL wb_readback got %h want beef", arr_rd(rf_ren1)); end
        tick();
        wb_we = 0;
        #1;
        checks++; if ({byp1, byp2} !== 2'b00) begin errors++; $display("FAIL wb_byp_idle got %b want 00", {byp1, byp2}); end
        checks++; if (arr_rd(rf_ren2) !== 16'h1357) begin errors++; $display("FAIL wb_readback2 got %h want 1357", arr_rd(rf_ren2)); end
    endtask

    task automatic test_r0_protect();
        wb_we = 1; wb_addr = 4'd0; wb_data = 16'hFFFF;
        dbg_req = 1; dbg_addr = 4'd3; dbg_data = 16'h1234;
        rd_addr1 = 4'd0; rd_addr2 = 4'd3;
        #1;
        checks++; if (dbg_ack !== 1'b1) begin errors++; $display("FAIL r0_dbg_ack got %b want 1", dbg_ack); end
        checks++; if (rf_wen !== 16'h0008) begin errors++; $display("FAIL r0_wen got %h want 0008", rf_wen); end
        checks++; if ({byp1, byp2} !== 2'b01) begin errors++; $display("FAIL r0_byp got %b want 01", {byp1, byp2}); end
        tick();
        // Debug write to R0 is acked and discarded.
        wb_we = 0; dbg_addr = 4'd0; dbg_data = 16'hAAAA;
        #1;
        checks++; if (dbg_ack !== 1'b1 || rf_wen !== 16'h0000) begin errors++; $display("FAIL r0_dbg_discard got %b/%h want 1/0000", dbg_ack, rf_wen); end
        tick();
        idle_inputs();
        #1;
        checks++; if (mem[0] !== 16'h0000) begin errors++; $display("FAIL r0_value got %h want 0000", mem[0]); end
        checks++; if (mem[3] !== 16'h1234) begin errors++; $display("FAIL r3_value got %h want 1234", mem[3]); end
    endtask

    task automatic test_starvation();
        logic exp_stall [4];
        exp_stall[0] = 0; exp_stall[1] = 0; exp_stall[2] = 0; exp_stall[3] = 1;
        wb_we = 1; wb_addr = 4'd2; wb_data = 16'h2222;
        dbg_req = 1; dbg_addr = 4'd7; dbg_data = 16'h00AA;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (stall !== exp_stall[c]) begin errors++; $display("FAIL starve_stall[%0d] got %b want %b", c, stall, exp_stall[c]); end
            checks++; if (dbg_ack !== 1'b0 || rf_wen !== 16'h0004) begin errors++; $display("FAIL starve_wait[%0d] got %b/%h want 0/0004", c, dbg_ack, rf_wen); end
            tick();
        end
        wb_we = 0;
        #1;
        checks++; if (dbg_ack !== 1'b1 || rf_wen !== 16'h0080) begin errors++; $display("FAIL starve_grant got %b/%h want 1/0080", dbg_ack, rf_wen); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL starve_stall_grant got %b want 1", stall); end
        tick();
        idle_inputs();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL starve_stall_after got %b want 0", stall); end
        checks++; if (mem[7] !== 16'h00AA) begin errors++; $display("FAIL starve_r7 got %h want 00aa", mem[7]); end
        checks++; if (mem[2] !== 16'h2222) begin errors++; $display("FAIL starve_r2 got %h want 2222", mem[2]); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp_wen;
        wb_we = 1; wb_addr = 4'd2; wb_data = 16'h3333;
        dbg_req = 1; dbg_addr = 4'd8; dbg_data = 16'h4444;
        #1;
        checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL mid_pending_ack got %b want 0", dbg_ack); end
        tick();
        rst = 0;
        #1;
        checks++; if (dbg_ack !== 1'b0 || rf_wen !== 16'h0 || busy !== 1'b1) begin errors++; $display("FAIL mid_run_reset got ack=%b wen=%h busy=%b want 0/0000/1", dbg_ack, rf_wen, busy); end
        tick();
        rst = 1;
        for (int k = 0; k < 9; k++) begin
            #1;
            exp_wen = 16'h0001 << k;
            checks++; if (rf_wen !== exp_wen || dbg_ack !== 1'b0) begin errors++; $display("FAIL mid_clear1[%0d] got %h/%b want %h/0", k, rf_wen, dbg_ack, exp_wen); end
            tick();
        end
        rst = 0;
        #1;
        checks++; if (rf_wen !== 16'h0000 || busy !== 1'b1) begin errors++; $display("FAIL mid_clear_reset got %h/%b want 0000/1", rf_wen, busy); end
        tick();
        rst = 1;
        idle_inputs();
        for (int k = 0; k < 16; k++) begin
            #1;
            exp_wen = 16'h0001 << k;
            checks++; if (rf_wen !== exp_wen || busy !== 1'b1) begin errors++; $display("FAIL mid_clear2[%0d] got %h/%b want %h/1", k, rf_wen, busy, exp_wen); end
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_done got %b want 0", busy); end
        checks++; if (mem[8] !== 16'h0000 || mem[2] !== 16'h0000 || mem[7] !== 16'h0000) begin errors++; $display("FAIL mid_regs got %h/%h/%h want 0000", mem[8], mem[2], mem[7]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_clear();
        test_writeback();
        test_r0_protect();
        test_starvation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
